// File: rtl/time_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : time_bcd_converter
//  Purpose  : Snapshots the time or alarm count (seconds since midnight),
//             optionally folds it to 12-hour form and converts it into six
//             BCD digits by iterative subtraction. All outputs are registered
//             and update together once per conversion.
//  Revision : 1.0 - initial release
// ============================================================================
module time_bcd_converter #(
  parameter int CNT_W    = 21,
  parameter int DAY_SEC  = 86400,
  parameter int HALF_SEC = 43200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] count_alarm,
  input  logic             alarm_en,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             pm,
  output logic [3:0]       hour1,
  output logic [3:0]       hour0,
  output logic [3:0]       min1,
  output logic [3:0]       min0,
  output logic [3:0]       sec1,
  output logic [3:0]       sec0
);

  localparam logic [CNT_W-1:0] c_DAY  = CNT_W'(DAY_SEC);
  localparam logic [CNT_W-1:0] c_HALF = CNT_W'(HALF_SEC);
  localparam logic [CNT_W-1:0] c_K_H10 = CNT_W'(36000);
  localparam logic [CNT_W-1:0] c_K_H1  = CNT_W'(3600);
  localparam logic [CNT_W-1:0] c_K_M10 = CNT_W'(600);
  localparam logic [CNT_W-1:0] c_K_M1  = CNT_W'(60);
  localparam logic [CNT_W-1:0] c_K_S10 = CNT_W'(10);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    H10  = 3'd2,
    H1   = 3'd3,
    M10  = 3'd4,
    M1   = 3'd5,
    S10  = 3'd6,
    FIN  = 3'd7
  } state_t;

  state_t           state_q, state_d;

  // Snapshot and working registers
  logic [CNT_W-1:0] src_q, src_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             mode12_q, mode12_d;
  logic             pm_n_q, pm_n_d;
  logic             errf_q, errf_d;
  logic [3:0]       h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d, s1_q, s1_d;

  // Output registers
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             pm_q, pm_d;
  logic [3:0]       hour1_q, hour1_d, hour0_q, hour0_d;
  logic [3:0]       min1_q, min1_d, min0_q, min0_d;
  logic [3:0]       sec1_q, sec1_d, sec0_q, sec0_d;

  // State and data registers; reset abandons any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      src_q    <= '0;
      rem_q    <= '0;
      mode12_q <= 1'b0;
      pm_n_q   <= 1'b0;
      errf_q   <= 1'b0;
      h1_q     <= '0;
      h0_q     <= '0;
      m1_q     <= '0;
      m0_q     <= '0;
      s1_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pm_q     <= 1'b0;
      hour1_q  <= '0;
      hour0_q  <= '0;
      min1_q   <= '0;
      min0_q   <= '0;
      sec1_q   <= '0;
      sec0_q   <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      rem_q    <= rem_d;
      mode12_q <= mode12_d;
      pm_n_q   <= pm_n_d;
      errf_q   <= errf_d;
      h1_q     <= h1_d;
      h0_q     <= h0_d;
      m1_q     <= m1_d;
      m0_q     <= m0_d;
      s1_q     <= s1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      pm_q     <= pm_d;
      hour1_q  <= hour1_d;
      hour0_q  <= hour0_d;
      min1_q   <= min1_d;
      min0_q   <= min0_d;
      sec1_q   <= sec1_d;
      sec0_q   <= sec0_d;
    end
  end

  // Next-state: capture, fold, one subtract-compare per cycle, then publish
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    rem_d    = rem_q;
    mode12_d = mode12_q;
    pm_n_d   = pm_n_q;
    errf_d   = errf_q;
    h1_d     = h1_q;
    h0_d     = h0_q;
    m1_d     = m1_q;
    m0_d     = m0_q;
    s1_d     = s1_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pm_d     = pm_q;
    hour1_d  = hour1_q;
    hour0_d  = hour0_q;
    min1_d   = min1_q;
    min0_d   = min0_q;
    sec1_d   = sec1_q;
    sec0_d   = sec0_q;

    unique case (state_q)
      IDLE: begin
        // done_q marks the cycle straight after FIN; a start there is
        // treated as arriving during the conversion and dropped.
        if (start && !done_q) begin
          src_d    = alarm_en ? count_alarm : count;
          mode12_d = mode;
          busy_d   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        h1_d = '0;
        h0_d = '0;
        m1_d = '0;
        m0_d = '0;
        s1_d = '0;
        if (src_q >= c_DAY) begin
          errf_d  = 1'b1;
          state_d = FIN;
        end else begin
          errf_d = 1'b0;
          if (mode12_q && (src_q >= c_HALF)) begin
            rem_d  = src_q - c_HALF;
            pm_n_d = 1'b1;
          end else begin
            rem_d  = src_q;
            pm_n_d = 1'b0;
          end
          state_d = H10;
        end
      end
      H10: begin
        if (rem_q >= c_K_H10) begin
          rem_d = rem_q - c_K_H10;
          h1_d  = h1_q + 4'd1;
        end else begin
          state_d = H1;
        end
      end
      H1: begin
        if (rem_q >= c_K_H1) begin
          rem_d = rem_q - c_K_H1;
          h0_d  = h0_q + 4'd1;
        end else begin
          state_d = M10;
        end
      end
      M10: begin
        if (rem_q >= c_K_M10) begin
          rem_d = rem_q - c_K_M10;
          m1_d  = m1_q + 4'd1;
        end else begin
          state_d = M1;
        end
      end
      M1: begin
        if (rem_q >= c_K_M1) begin
          rem_d = rem_q - c_K_M1;
          m0_d  = m0_q + 4'd1;
        end else begin
          state_d = S10;
        end
      end
      S10: begin
        if (rem_q >= c_K_S10) begin
          rem_d = rem_q - c_K_S10;
          s1_d  = s1_q + 4'd1;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (errf_q) begin
          err_d = 1'b1;
        end else begin
          // In 12-hour mode an hour of zero (midnight or noon) reads as 12
          if (mode12_q && (h1_q == 4'd0) && (h0_q == 4'd0)) begin
            hour1_d = 4'd1;
            hour0_d = 4'd2;
          end else begin
            hour1_d = h1_q;
            hour0_d = h0_q;
          end
          min1_d = m1_q;
          min0_d = m0_q;
          sec1_d = s1_q;
          sec0_d = rem_q[3:0];
          pm_d   = pm_n_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign pm    = pm_q;
  assign hour1 = hour1_q;
  assign hour0 = hour0_q;
  assign min1  = min1_q;
  assign min0  = min0_q;
  assign sec1  = sec1_q;
  assign sec0  = sec0_q;

endmodule
`default_nettype wire

// File: tb/tb_time_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_bcd_converter
//  Purpose  : Directed self-checking bench for time_bcd_converter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_time_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [20:0] count;
  logic [20:0] count_alarm;
  logic        alarm_en;
  logic        mode;
  logic        busy, done, err, pm;
  logic [3:0]  hour1, hour0, min1, min0, sec1, sec0;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int nd;

  always #5 clk = ~clk;

  time_bcd_converter #(
    .CNT_W   (21),
    .DAY_SEC (86400),
    .HALF_SEC(43200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .count      (count),
    .count_alarm(count_alarm),
    .alarm_en   (alarm_en),
    .mode       (mode),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pm         (pm),
    .hour1      (hour1),
    .hour0      (hour0),
    .min1       (min1),
    .min0       (min0),
    .sec1       (sec1),
    .sec0       (sec0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] digits();
    return {8'h00, hour1, hour0, min1, min0, sec1, sec0};
  endfunction

  // Pulses start one cycle after the call, returns edges from sampling edge
  // to done (or -1 on timeout). Optional pokes: zero count_alarm two cycles
  // in, and a second start pulse three cycles in.
  task automatic convert(input logic [20:0] c, input logic [20:0] ca,
                         input logic ae, input logic md,
                         input bit poke_alarm, input bit restart,
                         output int l);
    @(posedge clk); #1;
    count = c; count_alarm = ca; alarm_en = ae; mode = md; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = -1;
    if (done) l = 0;
    for (int k = 1; k <= 60 && l < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
      if (poke_alarm && k == 2) count_alarm = 21'd0;
      start = (restart && k == 3);
      if (done) l = k;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; count_alarm = '0; alarm_en = 1'b0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err_pm", {30'd0, err, pm}, 32'd0);
    check("rst_digits", digits(), 32'h000000);
    rst = 1'b0;

    // 00:00:00, 24-hour
    convert(21'd0, 21'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    check("zero_lat", lat, 7);
    check("zero_digits", digits(), 32'h000000);
    check("zero_pm_err", {30'd0, pm, err}, 32'd0);
    @(posedge clk); #1;
    check("zero_done_pulse", {31'd0, done}, 32'd0);
    check("zero_busy_low", {31'd0, busy}, 32'd0);

    // 23:59:59, 24-hour worst case
    convert(21'd86399, 21'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    check("max24_lat", lat, 31);
    check("max24_digits", digits(), 32'h235959);
    check("max24_pm", {31'd0, pm}, 32'd0);

    // 11:59:59 PM, 12-hour
    convert(21'd86399, 21'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat);
    check("max12_lat", lat, 28);
    check("max12_digits", digits(), 32'h115959);
    check("max12_pm", {31'd0, pm}, 32'd1);

    // Midnight in 12-hour mode reads 12:00:00 AM
    convert(21'd0, 21'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat);
    check("midnight_lat", lat, 7);
    check("midnight_digits", digits(), 32'h120000);
    check("midnight_pm", {31'd0, pm}, 32'd0);

    // Noon in 12-hour mode reads 12:00:00 PM
    convert(21'd43200, 21'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat);
    check("noon_digits", digits(), 32'h120000);
    check("noon_pm", {31'd0, pm}, 32'd1);

    // Alarm source, alarm input changed after capture
    convert(21'd3661, 21'd27000, 1'b1, 1'b0, 1'b1, 1'b0, lat);
    check("alarm_lat", lat, 17);
    check("alarm_digits", digits(), 32'h073000);

    // 01:01:01 then out-of-range value
    convert(21'd3661, 21'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    check("t010101_lat", lat, 9);
    check("t010101_digits", digits(), 32'h010101);
    convert(21'd86400, 21'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    check("oor_lat", lat, 2);
    check("oor_err", {31'd0, err}, 32'd1);
    check("oor_digits_held", digits(), 32'h010101);
    @(posedge clk); #1;
    check("oor_busy_low", {31'd0, busy}, 32'd0);
    check("oor_err_pulse", {31'd0, err}, 32'd0);

    // Second start while busy is ignored
    convert(21'd45296, 21'd0, 1'b0, 1'b0, 1'b0, 1'b1, lat);
    check("restart_lat", lat, 22);
    check("restart_digits", digits(), 32'h123456);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("restart_extra_done", nd, 0);

    // Reset in the middle of a conversion
    @(posedge clk); #1;
    count = 21'd86399; mode = 1'b0; alarm_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_digits", digits(), 32'h000000);
    check("midrst_flags", {28'd0, busy, done, err, pm}, 32'd0);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("midrst_no_done", nd, 0);

    // Fresh conversion after reset: 12:34:56 PM in 12-hour mode
    convert(21'd45296, 21'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat);
    check("post_rst_lat", lat, 19);
    check("post_rst_digits", digits(), 32'h123456);
    check("post_rst_pm", {31'd0, pm}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
